// File: rtl/jerky_count_ctrl.sv
// Command-driven jerky counter: steps by STEP_A/STEP_B alternately up to a programmed limit, clamping.
// Latency: accepted command visible on outputs one cycle later; one step per cycle while running.
// Backpressure: cmd_ready low only during the one-cycle DONE state. Optional AUTO_RESTART_EN loops runs.
module jerky_count_ctrl #(
    parameter int WIDTH  = 8,
    parameter int STEP_A = 1,
    parameter int STEP_B = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             paused,
    output logic             done
);

    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_PAUSE  = 2'b01;
    localparam logic [1:0] OP_RESUME = 2'b10;
    localparam logic [1:0] OP_ABORT  = 2'b11;

    localparam logic [WIDTH:0] STRIDE_A = (WIDTH+1)'(STEP_A);
    localparam logic [WIDTH:0] STRIDE_B = (WIDTH+1)'(STEP_B);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] limit;
    logic             phase_b;
    logic             accept;
    logic [WIDTH:0]   stride;
    logic [WIDTH:0]   nxt;

    assign cmd_ready = (state != DONE);
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state == RUN) || (state == PAUSE);
    assign paused    = (state == PAUSE);
    assign done      = (state == DONE);

    // One extra bit so overshoot past the top of the range is caught, not wrapped.
    assign stride = phase_b ? STRIDE_B : STRIDE_A;
    assign nxt    = {1'b0, count} + stride;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            limit   <= '0;
            phase_b <= 1'b0;
        end else if (accept && cmd_op == OP_START) begin
            count   <= '0;
            limit   <= cmd_limit;
            phase_b <= 1'b0;
            state   <= (cmd_limit == '0) ? DONE : RUN;
        end else begin
            case (state)
                IDLE: begin
                end
                RUN: begin
                    // An accepted command consumes the edge; no step alongside it.
                    if (accept) begin
                        if (cmd_op == OP_PAUSE)
                            state <= PAUSE;
                        else if (cmd_op == OP_ABORT)
                            state <= IDLE;
                    end else if (nxt >= {1'b0, limit}) begin
                        count <= limit;
                        state <= DONE;
                    end else begin
                        count   <= nxt[WIDTH-1:0];
                        phase_b <= ~phase_b;
                    end
                end
                PAUSE: begin
                    if (accept) begin
                        if (cmd_op == OP_RESUME)
                            state <= RUN;
                        else if (cmd_op == OP_ABORT)
                            state <= IDLE;
                    end
                end
                DONE: begin
`ifdef AUTO_RESTART_EN
                    state   <= RUN;
                    count   <= '0;
                    phase_b <= 1'b0;
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jerky_count_ctrl.sv
// Directed bench for jerky_count_ctrl: drives and samples on the falling edge.
module tb_jerky_count_ctrl;

    localparam int W = 8;
    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_PAUSE  = 2'b01;
    localparam logic [1:0] OP_RESUME = 2'b10;
    localparam logic [1:0] OP_ABORT  = 2'b11;

    logic         clock     = 1'b0;
    logic         reset     = 1'b0;
    logic         cmd_valid = 1'b0;
    logic [1:0]   cmd_op    = 2'b00;
    logic [W-1:0] cmd_limit = '0;
    logic         cmd_ready;
    logic [W-1:0] count;
    logic         busy;
    logic         paused;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    jerky_count_ctrl #(.WIDTH(W), .STEP_A(1), .STEP_B(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_limit (cmd_limit),
        .count     (count),
        .busy      (busy),
        .paused    (paused),
        .done      (done)
    );

    // Status nibble = {busy, paused, done, cmd_ready}
    task automatic send(input logic [1:0] op, input logic [W-1:0] lim);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_limit = lim;
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_limit = '0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if (count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++;
        if ({busy, paused, done} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b expected 000", {busy, paused, done}); end
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_basic;
        logic [7:0] exp [0:6];
        exp = '{8'd0, 8'd1, 8'd4, 8'd5, 8'd8, 8'd9, 8'd10};
        send(OP_START, 8'd10);
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (count !== exp[i]) begin n_fail++; $display("FAIL basic_count[%0d]: got %0d expected %0d", i, count, exp[i]); end
            n_checks++;
            if ({busy, paused, done, cmd_ready} !== (i == 6 ? 4'b0010 : 4'b1001)) begin
                n_fail++; $display("FAIL basic_status[%0d]: got %b expected %b", i, {busy, paused, done, cmd_ready}, (i == 6 ? 4'b0010 : 4'b1001));
            end
            @(negedge clock);
        end
        n_checks++;
        if (count !== 8'd10 || {busy, paused, done, cmd_ready} !== 4'b0001) begin
            n_fail++; $display("FAIL basic_idle: got count %0d status %b expected 10 0001", count, {busy, paused, done, cmd_ready});
        end
    endtask

    task automatic test_pause_resume;
        logic [7:0] exp [0:7];
        exp = '{8'd5, 8'd8, 8'd9, 8'd12, 8'd13, 8'd16, 8'd17, 8'd20};
        send(OP_START, 8'd20);
        repeat (2) @(negedge clock);
        send(OP_PAUSE, 8'd0);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (count !== 8'd4 || {busy, paused, done, cmd_ready} !== 4'b1101) begin
                n_fail++; $display("FAIL pause_hold[%0d]: got count %0d status %b expected 4 1101", i, count, {busy, paused, done, cmd_ready});
            end
            if (i < 5) @(negedge clock);
        end
        send(OP_RESUME, 8'd0);
        n_checks++;
        if (count !== 8'd4 || {busy, paused, done, cmd_ready} !== 4'b1001) begin
            n_fail++; $display("FAIL resume_state: got count %0d status %b expected 4 1001", count, {busy, paused, done, cmd_ready});
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            n_checks++;
            if (count !== exp[i] || done !== (i == 7)) begin
                n_fail++; $display("FAIL resume_count[%0d]: got %0d done %b expected %0d done %b", i, count, done, exp[i], (i == 7));
            end
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [0:3];
        exp = '{8'd1, 8'd4, 8'd5, 8'd6};
        send(OP_START, 8'd20);
        send(OP_RESUME, 8'd0);
        n_checks++;
        if (count !== 8'd0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL collide_hold: got count %0d busy %b expected 0 1", count, busy);
        end
        repeat (2) @(negedge clock);
        send(OP_START, 8'd6);
        n_checks++;
        if (count !== 8'd0 || {busy, paused, done, cmd_ready} !== 4'b1001) begin
            n_fail++; $display("FAIL restart: got count %0d status %b expected 0 1001", count, {busy, paused, done, cmd_ready});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_checks++;
            if (count !== exp[i] || done !== (i == 3)) begin
                n_fail++; $display("FAIL restart_count[%0d]: got %0d done %b expected %0d done %b", i, count, done, exp[i], (i == 3));
            end
        end
        @(negedge clock);
    endtask

    task automatic test_abort;
        send(OP_START, 8'd50);
        repeat (4) @(negedge clock);
        n_checks++;
        if (count !== 8'd8) begin n_fail++; $display("FAIL abort_pre: got %0d expected 8", count); end
        send(OP_ABORT, 8'd0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (count !== 8'd8 || {busy, paused, done, cmd_ready} !== 4'b0001) begin
                n_fail++; $display("FAIL abort_idle[%0d]: got count %0d status %b expected 8 0001", i, count, {busy, paused, done, cmd_ready});
            end
            @(negedge clock);
        end
        send(OP_START, 8'd3);
        n_checks++;
        if (count !== 8'd0) begin n_fail++; $display("FAIL abort_rs0: got %0d expected 0", count); end
        @(negedge clock);
        n_checks++;
        if (count !== 8'd1) begin n_fail++; $display("FAIL abort_rs1: got %0d expected 1", count); end
        @(negedge clock);
        n_checks++;
        if (count !== 8'd3 || done !== 1'b1) begin n_fail++; $display("FAIL abort_rs_clamp: got %0d done %b expected 3 done 1", count, done); end
        @(negedge clock);
    endtask

    task automatic test_limit_max;
        send(OP_START, 8'd255);
        repeat (126) @(negedge clock);
        n_checks++;
        if (count !== 8'd252) begin n_fail++; $display("FAIL max_252: got %0d expected 252", count); end
        @(negedge clock);
        n_checks++;
        if (count !== 8'd253 || done !== 1'b0) begin n_fail++; $display("FAIL max_253: got %0d done %b expected 253 done 0", count, done); end
        @(negedge clock);
        n_checks++;
        if (count !== 8'd255 || done !== 1'b1) begin n_fail++; $display("FAIL max_clamp: got %0d done %b expected 255 done 1", count, done); end
        @(negedge clock);
        n_checks++;
        if (count !== 8'd255 || {busy, paused, done, cmd_ready} !== 4'b0001) begin
            n_fail++; $display("FAIL max_idle: got count %0d status %b expected 255 0001", count, {busy, paused, done, cmd_ready});
        end
    endtask

    task automatic test_limit_zero;
        send(OP_START, 8'd0);
        n_checks++;
        if (count !== 8'd0 || {busy, paused, done, cmd_ready} !== 4'b0010) begin
            n_fail++; $display("FAIL zero_done: got count %0d status %b expected 0 0010", count, {busy, paused, done, cmd_ready});
        end
        send(OP_START, 8'd7);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (count !== 8'd0 || {busy, paused, done, cmd_ready} !== 4'b0001) begin
                n_fail++; $display("FAIL done_reject[%0d]: got count %0d status %b expected 0 0001", i, count, {busy, paused, done, cmd_ready});
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset_mid_run;
        send(OP_START, 8'd20);
        repeat (3) @(negedge clock);
        n_checks++;
        if (count !== 8'd5) begin n_fail++; $display("FAIL midrst_pre: got %0d expected 5", count); end
        reset     = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = OP_START;
        cmd_limit = 8'd9;
        @(negedge clock);
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_limit = '0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (count !== 8'd0 || {busy, paused, done, cmd_ready} !== 4'b0001) begin
                n_fail++; $display("FAIL midrst_idle[%0d]: got count %0d status %b expected 0 0001", i, count, {busy, paused, done, cmd_ready});
            end
            @(negedge clock);
        end
        send(OP_START, 8'd4);
        @(negedge clock);
        n_checks++;
        if (count !== 8'd1) begin n_fail++; $display("FAIL midrst_run1: got %0d expected 1", count); end
        @(negedge clock);
        n_checks++;
        if (count !== 8'd4 || done !== 1'b1) begin n_fail++; $display("FAIL midrst_run4: got %0d done %b expected 4 done 1", count, done); end
        @(negedge clock);
    endtask

`ifdef AUTO_RESTART_EN
    task automatic test_auto_restart;
        logic [7:0] exp [0:8];
        exp = '{8'd0, 8'd1, 8'd4, 8'd5, 8'd0, 8'd1, 8'd4, 8'd5, 8'd0};
        send(OP_START, 8'd5);
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (count !== exp[i] || done !== (i == 3 || i == 7) || busy !== !(i == 3 || i == 7)) begin
                n_fail++; $display("FAIL auto_count[%0d]: got %0d done %b busy %b expected %0d", i, count, done, busy, exp[i]);
            end
            @(negedge clock);
        end
        send(OP_ABORT, 8'd0);
        n_checks++;
        if (count !== 8'd1 || {busy, paused, done, cmd_ready} !== 4'b0001) begin
            n_fail++; $display("FAIL auto_abort: got count %0d status %b expected 1 0001", count, {busy, paused, done, cmd_ready});
        end
    endtask
`endif

    initial begin
        test_reset;
`ifdef AUTO_RESTART_EN
        test_auto_restart;
`else
        test_basic;
        test_pause_resume;
        test_back_to_back;
        test_abort;
        test_limit_max;
        test_limit_zero;
        test_reset_mid_run;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
